// File: rtl/unidade_controle_if.sv
// Bundle between the control unit and its surroundings: instruction fetch port,
// register-file/ALU control, ALU flags and the data-memory handshake.
interface unidade_controle_if #(
    parameter int bits_palavra  = 16,
    parameter int bits_controle = 5
);
    logic                     instr_req;
    logic [bits_palavra-1:0]  instr_endereco;
    logic                     instr_valido;
    logic [bits_palavra-1:0]  instrucao;
    logic [bits_controle-1:0] controle;
    logic [2:0]               sel_regA;
    logic [2:0]               sel_regB;
    logic [2:0]               sel_regDest;
    logic                     escreve_reg;
    logic [1:0]               sel_fonte;
    logic [bits_palavra-1:0]  constante;
    logic                     Z;
    logic                     C;
    logic                     N;
    logic                     O;
    logic                     mem_req;
    logic                     mem_escrita;
    logic                     mem_pronto;
    logic                     parado;

    modport master (
        output instr_req, instr_endereco, controle, sel_regA, sel_regB, sel_regDest,
               escreve_reg, sel_fonte, constante, mem_req, mem_escrita, parado,
        input  instr_valido, instrucao, Z, C, N, O, mem_pronto
    );

    modport slave (
        input  instr_req, instr_endereco, controle, sel_regA, sel_regB, sel_regDest,
               escreve_reg, sel_fonte, constante, mem_req, mem_escrita, parado,
        output instr_valido, instrucao, Z, C, N, O, mem_pronto
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches, decodes and sequences ALU, load-constant,
// conditional-jump, load/store and halt instructions.
module unidade_controle #(
    parameter int bits_palavra  = 16,
    parameter int bits_controle = 5
) (
    input logic                clock,
    input logic                reset,
    unidade_controle_if.master bus
);
    localparam logic [2:0] BUSCA      = 3'd0;
    localparam logic [2:0] DECODIFICA = 3'd1;
    localparam logic [2:0] EXECUTA    = 3'd2;
    localparam logic [2:0] MEMORIA    = 3'd3;
    localparam logic [2:0] PARADO     = 3'd4;

    localparam logic [1:0] FMT_ULA   = 2'b00;
    localparam logic [1:0] FMT_CONST = 2'b01;
    localparam logic [1:0] FMT_SALTO = 2'b10;
    localparam logic [1:0] FMT_MEM   = 2'b11;

    localparam logic [bits_controle-1:0] CTRL_NEUTRO = bits_controle'(16);

    logic [2:0]              estado_q, estado_d;
    logic [bits_palavra-1:0] pc_q, pc_d;
    logic [bits_palavra-1:0] ir_q, ir_d;
    logic [3:0]              flags_q, flags_d;
    logic [1:0]              formato;
    logic [bits_palavra-1:0] imediato;
    logic                    condicao;
    logic                    carga_pronta;

    assign formato      = ir_q[15:14];
    assign imediato     = {{(bits_palavra-11){ir_q[10]}}, ir_q[10:0]};
    assign carga_pronta = (estado_q == MEMORIA) && bus.mem_pronto && !ir_q[13];

    // Jump conditions look at the latched flags {Z, C, N, O}, not the live ALU inputs.
    always_comb begin
        condicao = 1'b0;
        case (ir_q[13:11])
            3'b000: condicao = 1'b1;
            3'b001: condicao = flags_q[3];
            3'b010: condicao = !flags_q[3];
            3'b011: condicao = flags_q[1];
            3'b100: condicao = !flags_q[1];
            3'b101: condicao = flags_q[2];
            3'b110: condicao = flags_q[0];
            default: condicao = 1'b0;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        flags_d  = flags_q;
        case (estado_q)
            BUSCA: begin
                if (bus.instr_valido) begin
                    ir_d     = bus.instrucao;
                    pc_d     = pc_q + bits_palavra'(1);
                    estado_d = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (formato != FMT_MEM) begin
                    estado_d = EXECUTA;
                end else if (ir_q[12]) begin
                    estado_d = PARADO;
                end else begin
                    estado_d = MEMORIA;
                end
            end
            EXECUTA: begin
                if (formato == FMT_ULA) begin
                    flags_d = {bus.Z, bus.C, bus.N, bus.O};
                end else if (formato == FMT_SALTO && condicao) begin
                    pc_d = pc_q + imediato;
                end
                estado_d = BUSCA;
            end
            MEMORIA: begin
                if (bus.mem_pronto) begin
                    estado_d = BUSCA;
                end
            end
            PARADO: estado_d = PARADO;
            // Unused encodings fall back to fetch so a corrupted state cannot lock up.
            default: estado_d = BUSCA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= BUSCA;
            pc_q     <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flags_q  <= flags_d;
        end
    end

    // Requests and write enables are forced low while reset is held.
    always_comb begin
        bus.instr_req      = 1'b0;
        bus.instr_endereco = pc_q;
        bus.controle       = CTRL_NEUTRO;
        bus.escreve_reg    = 1'b0;
        bus.sel_fonte      = 2'b00;
        bus.mem_req        = 1'b0;
        bus.mem_escrita    = 1'b0;
        bus.parado         = 1'b0;
        bus.sel_regA       = ir_q[5:3];
        bus.sel_regB       = ir_q[2:0];
        bus.sel_regDest    = (formato == FMT_CONST) ? ir_q[13:11] : ir_q[8:6];
        bus.constante      = imediato;
        if (!reset) begin
            case (estado_q)
                BUSCA: bus.instr_req = 1'b1;
                EXECUTA: begin
                    if (formato == FMT_ULA) begin
                        bus.controle    = ir_q[13:9];
                        bus.escreve_reg = 1'b1;
                    end else if (formato == FMT_CONST) begin
                        bus.escreve_reg = 1'b1;
                        bus.sel_fonte   = 2'b01;
                    end
                end
                MEMORIA: begin
                    bus.mem_req     = 1'b1;
                    bus.mem_escrita = ir_q[13];
                    if (carga_pronta) begin
                        bus.escreve_reg = 1'b1;
                        bus.sel_fonte   = 2'b10;
                    end
                end
                PARADO: bus.parado = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks a short hand-assembled program
// through fetch, ALU, constant, jumps, load/store, halt and reset cases.
module tb_unidade_controle;
    logic clock;
    logic reset;
    int   testCount;
    int   failCount;

    unidade_controle_if bus ();

    unidade_controle dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valido, input logic [15:0] palavra,
                                 input logic pronto, input logic [3:0] zcno);
        bus.instr_valido = valido;
        bus.instrucao    = palavra;
        bus.mem_pronto   = pronto;
        {bus.Z, bus.C, bus.N, bus.O} = zcno;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one instruction word for a single fetch edge, then withdraws it.
    task automatic fetch(input logic [15:0] palavra, input logic [3:0] zcno);
        applyStimulus(1'b1, palavra, 1'b0, zcno);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, zcno);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;

        reset = 1'b1;
        applyStimulus(1'b1, 16'hD000, 1'b1, 4'b0000);
        tick();
        checkOutput("rst_instr_req", {15'd0, bus.instr_req}, 16'd0);
        checkOutput("rst_mem_req", {15'd0, bus.mem_req}, 16'd0);
        checkOutput("rst_escreve", {15'd0, bus.escreve_reg}, 16'd0);
        checkOutput("rst_parado", {15'd0, bus.parado}, 16'd0);
        tick();
        checkOutput("rst_pc", bus.instr_endereco, 16'h0000);

        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 4'b0000);
        checkOutput("busca_req", {15'd0, bus.instr_req}, 16'd1);
        checkOutput("busca_end0", bus.instr_endereco, 16'h0000);
        tick();
        checkOutput("busca_espera_pc", bus.instr_endereco, 16'h0000);
        checkOutput("busca_espera_req", {15'd0, bus.instr_req}, 16'd1);

        // Address 0: ALU op 0x0000 with clear flags
        fetch(16'h0000, 4'b0000);
        checkOutput("dec_pc1", bus.instr_endereco, 16'h0001);
        checkOutput("dec_controle", {11'd0, bus.controle}, 16'h0010);
        checkOutput("dec_escreve", {15'd0, bus.escreve_reg}, 16'd0);
        tick();
        checkOutput("ula_controle", {11'd0, bus.controle}, 16'h0000);
        checkOutput("ula_escreve", {15'd0, bus.escreve_reg}, 16'd1);
        checkOutput("ula_fonte", {14'd0, bus.sel_fonte}, 16'd0);
        tick();
        checkOutput("ula_volta_busca", {15'd0, bus.instr_req}, 16'd1);

        // Address 1: load constant 0x47FF, Z driven high but must not latch
        fetch(16'h47FF, 4'b1000);
        checkOutput("const_sext", bus.constante, 16'hFFFF);
        tick();
        checkOutput("const_fonte", {14'd0, bus.sel_fonte}, 16'd1);
        checkOutput("const_escreve", {15'd0, bus.escreve_reg}, 16'd1);
        checkOutput("const_controle", {11'd0, bus.controle}, 16'h0010);
        checkOutput("const_dest", {13'd0, bus.sel_regDest}, 16'd0);
        tick();

        // Address 2: jump if Z offset +3; Z still 0 so falls through to 3
        fetch(16'h8803, 4'b0000);
        tick();
        tick();
        checkOutput("flags_inalteradas", bus.instr_endereco, 16'h0003);

        // Address 3: ALU funcao 01010, rd3 ra5 rb6
        fetch(16'h14EE, 4'b0010);
        checkOutput("sel_regA", {13'd0, bus.sel_regA}, 16'd5);
        checkOutput("sel_regB", {13'd0, bus.sel_regB}, 16'd6);
        checkOutput("sel_regDest", {13'd0, bus.sel_regDest}, 16'd3);
        tick();
        checkOutput("ula_controle2", {11'd0, bus.controle}, 16'h000A);
        tick();

        // Address 4: ALU op latching Z=1; address 5: jump Z offset -1
        fetch(16'h0000, 4'b1000);
        tick();
        tick();
        fetch(16'h8FFF, 4'b0000);
        tick();
        tick();
        checkOutput("salto_z_tomado", bus.instr_endereco, 16'h0005);
        fetch(16'h97FF, 4'b0000);
        tick();
        tick();
        checkOutput("salto_nz_nao_tomado", bus.instr_endereco, 16'h0006);

        // Address 6: load rd2 via r4, ready after three wait cycles
        fetch(16'hC0A0, 4'b0000);
        checkOutput("load_pc7", bus.instr_endereco, 16'h0007);
        tick();
        checkOutput("load_req1", {15'd0, bus.mem_req}, 16'd1);
        checkOutput("load_escrita", {15'd0, bus.mem_escrita}, 16'd0);
        checkOutput("load_escreve_cedo", {15'd0, bus.escreve_reg}, 16'd0);
        checkOutput("load_dest", {13'd0, bus.sel_regDest}, 16'd2);
        checkOutput("load_end_reg", {13'd0, bus.sel_regA}, 16'd4);
        tick();
        checkOutput("load_req2", {15'd0, bus.mem_req}, 16'd1);
        tick();
        checkOutput("load_req3", {15'd0, bus.mem_req}, 16'd1);
        checkOutput("load_fonte_cedo", {14'd0, bus.sel_fonte}, 16'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 4'b0000);
        checkOutput("load_req4", {15'd0, bus.mem_req}, 16'd1);
        checkOutput("load_escreve", {15'd0, bus.escreve_reg}, 16'd1);
        checkOutput("load_fonte", {14'd0, bus.sel_fonte}, 16'd2);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 4'b0000);
        checkOutput("load_fim_req", {15'd0, bus.mem_req}, 16'd0);
        checkOutput("load_fim_busca", bus.instr_endereco, 16'h0007);

        // Address 7: store, ready immediately
        fetch(16'hE0A0, 4'b0000);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 4'b0000);
        checkOutput("store_escrita", {15'd0, bus.mem_escrita}, 16'd1);
        checkOutput("store_sem_escrita_reg", {15'd0, bus.escreve_reg}, 16'd0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 4'b0000);
        checkOutput("store_fim", {15'd0, bus.instr_req}, 16'd1);

        // Address 8: load interrupted by reset while waiting
        fetch(16'hC0A0, 4'b0000);
        tick();
        checkOutput("mem_espera_req", {15'd0, bus.mem_req}, 16'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 4'b0000);
        checkOutput("rst_mem_req_comb", {15'd0, bus.mem_req}, 16'd0);
        tick();
        checkOutput("rst_mem_req_pos", {15'd0, bus.mem_req}, 16'd0);
        checkOutput("rst_mem_pc", bus.instr_endereco, 16'h0000);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 4'b0000);
        checkOutput("rst_mem_busca", {15'd0, bus.instr_req}, 16'd1);

        // Halt word at address 0, then extra offered words must be ignored
        fetch(16'hD000, 4'b0000);
        tick();
        checkOutput("halt_parado", {15'd0, bus.parado}, 16'd1);
        applyStimulus(1'b1, 16'h0000, 1'b1, 4'b0000);
        tick();
        tick();
        tick();
        checkOutput("halt_parado_fixo", {15'd0, bus.parado}, 16'd1);
        checkOutput("halt_sem_req", {15'd0, bus.instr_req}, 16'd0);
        checkOutput("halt_pc", bus.instr_endereco, 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 4'b0000);
        checkOutput("halt_rst_parado", {15'd0, bus.parado}, 16'd0);
        checkOutput("halt_rst_pc", bus.instr_endereco, 16'h0000);

        // Address 0: always-jump offset -2 wraps to 0xFFFF; then never-jump wraps PC+1 to 0
        fetch(16'h87FE, 4'b0000);
        tick();
        tick();
        checkOutput("salto_wrap", bus.instr_endereco, 16'hFFFF);
        fetch(16'hBFFF, 4'b0000);
        checkOutput("pc_wrap", bus.instr_endereco, 16'h0000);
        tick();
        tick();
        checkOutput("salto_nunca", bus.instr_endereco, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameters SHALL be:
- bits_palavra, 16, instruction/data/address width.
- bits_controle, 5, ALU operation code width.
REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr_req  out  1  instruction fetch request.
- instr_endereco  out  16  fetch address (equals PC).
- instr_valido  in  1  instruction word valid.
- instrucao  in  16  instruction word.
- controle  out  5  ALU operation code.
- sel_regA, sel_regB, sel_regDest  out  3 each  register file read A, read B and write addresses.
- escreve_reg  out  1  register file write enable.
- sel_fonte  out  2  writeback source: 00 ALU, 01 constante, 10 memory.
- constante  out  16  sign-extended immediate.
- Z, C, N, O  in  1 each  ALU flags, same cycle as controle.
- mem_req  out  1  data memory request.
- mem_escrita  out  1  1 = store, 0 = load; meaningful only while mem_req=1.
- mem_pronto  in  1  memory access complete.
- parado  out  1  core halted.

Function
REQ-003 Instruction decode SHALL use bits [15:14] of IR as follows:
- 00 ALU: [13:9] funcao, [8:6] rd, [5:3] ra, [2:0] rb.
- 01 load constant: [13:11] rd, [10:0] imm.
- 10 conditional jump: [13:11] cond, [10:0] offset.
- 11 memory: [13]=1 store / 0 load, [12]=1 halt, [8:6] rd/rs, [5:3] address register.
REQ-004 The FSM SHALL have states BUSCA, DECODIFICA, EXECUTA, MEMORIA and PARADO; it SHALL be binary encoded and SHALL leave no unreachable state without a recovery path.
REQ-005 In BUSCA, instr_req SHALL be 1 and instr_endereco SHALL equal PC; on a cycle with instr_valido=1, IR SHALL load instrucao, PC SHALL become PC+1 (mod 2^16), and the next state SHALL be DECODIFICA.
REQ-006 While instr_valido=0 in BUSCA, the FSM SHALL remain in BUSCA with PC and IR unchanged.
REQ-007 DECODIFICA SHALL last exactly one cycle, with these next states:
- formats 00/01/10 -> EXECUTA.
- format 11 with [12]=0 -> MEMORIA.
- format 11 with [12]=1 -> PARADO.
REQ-008 sel_regA, sel_regB, sel_regDest and constante SHALL be driven combinationally from IR in all states; constante SHALL equal IR[10:0] sign-extended to 16 bits.
REQ-009 In EXECUTA with format 00, the block SHALL:
- drive controle=IR[13:9], escreve_reg=1 and sel_fonte=00;
- latch Z, C, N, O into the internal flag register at the clock edge.
REQ-010 In EXECUTA with format 01, the block SHALL drive escreve_reg=1 and sel_fonte=01, and SHALL leave the flags unchanged.
REQ-011 In EXECUTA with format 10, PC SHALL become PC + sext(offset) (mod 2^16) if the condition holds, else remain unchanged; flags SHALL be unchanged.
- cond 000: always.
- cond 001: Z=1.
- cond 010: Z=0.
- cond 011: N=1.
- cond 100: N=0.
- cond 101: C=1.
- cond 110: O=1.
- cond 111: never.
REQ-012 EXECUTA SHALL last exactly one cycle and SHALL always be followed by BUSCA.
REQ-013 In MEMORIA, the block SHALL:
- hold mem_req=1 and mem_escrita=IR[13] until mem_pronto=1;
- on a load, assert escreve_reg=1 with sel_fonte=10 in that same cycle (none on a store);
- go to BUSCA on the following edge.
REQ-014 PARADO SHALL be absorbing: parado=1, all requests and escreve_reg=0; only reset exits it.
REQ-015 Outside EXECUTA with format 00, controle SHALL be 5'b10000; outside the states named above, escreve_reg, mem_req and mem_escrita SHALL be 0 and sel_fonte SHALL be 00.
REQ-016 A jump to PC+sext(offset) SHALL wrap modulo 2^16 (e.g. PC=0x0001, offset=-2 -> 0xFFFF).
REQ-017 Minimum cycles per instruction (no wait states) SHALL be: 3 for ALU, constant and jump; 3 for memory.

Reset
REQ-018 At any clock edge with reset=1, the block SHALL set state=BUSCA, PC=0, IR=0 and flags=0, regardless of the current state, including mid-MEMORIA and PARADO.
REQ-019 While reset=1, instr_req, mem_req, escreve_reg and parado SHALL be 0; a pending mem_pronto or instr_valido SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then instr_valido=1 with 0x0000 at address 0 -> instr_req=1, instr_endereco=0; PC=1 after one cycle; controle=00000 and escreve_reg=1 two cycles later.
- Load constant 0x47FF (rd=0, imm=0x7FF) -> constante=0xFFFF, sel_fonte=01, escreve_reg=1 in EXECUTA; flags unchanged.
- ALU op with Z=1 latched, then jump cond 001 with offset -1 at PC=5 -> next fetch address 0x0005; with cond 010, next fetch 0x0006.
- Load with mem_pronto delayed 3 cycles -> mem_req=1 for 4 cycles, mem_escrita=0, escreve_reg=1 with sel_fonte=10 only in the pronto cycle.
- Halt word 0xD000 -> parado=1 permanently; reset asserted -> parado=0 and fetch from address 0.
- Reset asserted during MEMORIA wait -> mem_req=0 after that edge; PC=0 and state=BUSCA.
